avalon_master_mm_interface: RTL

Avalon-MM master that runs single-word or block read/write transfers on behalf of user logic and drives them onto the Avalon-MM fabric. It is the initiator counterpart of our memory-mapped register slaves. User logic issues one command: direction, base address, word count. The block sequences the bus beats, honours `waitrequest`, returns read data with fixed read latency, and reports completion or timeout.

---
 rtl/avalon_mm_pkg.sv | 21 ++
 rtl/avalon_rd_capture.sv | 51 +++++
 rtl/avalon_master_mm_interface.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/avalon_mm_pkg.sv
// Shared state encoding and parameter defaults for the Avalon-MM master and its helpers.
package avalon_mm_pkg;

    localparam int unsigned DefAddrW   = 32;
    localparam int unsigned DefDataW   = 32;
    localparam int unsigned DefLenW    = 8;
    localparam int unsigned DefTimeout = 255;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StXfer  = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } xfer_state_e;

    // Width of a counter that must reach max_val without wrapping.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/avalon_rd_capture.sv
// Tracks accepted read beats through the fixed slave latency and registers returned data.
module avalon_rd_capture
    import avalon_mm_pkg::*;
#(
    parameter int unsigned DATA_W       = DefDataW,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              accept,
    input  logic [DATA_W-1:0] avm_readdata,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              empty
);

    logic [READ_LATENCY-1:0] pending_q, pending_d;
    logic [DATA_W-1:0]       rd_data_q;
    logic                    rd_valid_q;
    logic                    capture;

    // Bit i set means a read accepted i+1 cycles ago is still in flight.
    always_comb begin
        pending_d    = '0;
        pending_d[0] = accept;
        for (int i = 1; i < int'(READ_LATENCY); i++) begin
            pending_d[i] = pending_q[i-1];
        end
    end

    assign capture = pending_q[READ_LATENCY-1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending_q  <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            rd_valid_q <= capture;
            if (capture) begin
                rd_data_q <= avm_readdata;
            end
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign empty    = ~|pending_q;

endmodule

// File: rtl/avalon_master_mm_interface.sv
// Avalon-MM master: runs single or block read/write commands from user logic onto the fabric,
// honouring waitrequest, returning read data at fixed latency and flagging stall timeouts.
module avalon_master_mm_interface
    import avalon_mm_pkg::*;
#(
    parameter int unsigned ADDR_W       = DefAddrW,
    parameter int unsigned DATA_W       = DefDataW,
    parameter int unsigned LEN_W        = DefLenW,
    parameter int unsigned ADDR_STEP    = 1,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned TIMEOUT      = DefTimeout
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              op_write,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic              error,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_pop,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_chipselect,
    output logic              avm_read,
    output logic              avm_write,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_waitrequest
);

    localparam int unsigned CntW = cnt_width(TIMEOUT);

    xfer_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  remaining_q;
    logic              dir_q;
    logic [CntW-1:0]   wait_cnt_q;
    logic              error_q;

    logic start_ok;
    logic beat_ok;
    logic last_beat;
    logic timeout_hit;
    logic rd_accept;
    logic rd_empty;

    assign start_ok    = (state_q == StIdle) && start;
    assign beat_ok     = (state_q == StXfer) && !avm_waitrequest;
    assign last_beat   = beat_ok && (remaining_q == LEN_W'(1));
    assign timeout_hit = (state_q == StXfer) && avm_waitrequest
                         && (wait_cnt_q == CntW'(TIMEOUT - 1));
    assign rd_accept   = beat_ok && !dir_q;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = (length == '0) ? StDone : StXfer;
                end
            end
            StXfer: begin
                // Reads still have data in flight after the last beat; writes are finished.
                if (last_beat || timeout_hit) begin
                    state_d = dir_q ? StDone : StDrain;
                end
            end
            StDrain: begin
                if (rd_empty) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output logic
    always_comb begin
        busy           = 1'b0;
        done           = 1'b0;
        avm_chipselect = 1'b0;
        avm_read       = 1'b0;
        avm_write      = 1'b0;
        avm_address    = '0;
        avm_writedata  = '0;
        wr_pop         = 1'b0;
        unique case (state_q)
            StXfer: begin
                busy           = 1'b1;
                avm_chipselect = 1'b1;
                avm_read       = !dir_q;
                avm_write      = dir_q;
                avm_address    = addr_q;
                if (dir_q) begin
                    avm_writedata = wr_data;
                    wr_pop        = !avm_waitrequest;
                end
            end
            StDrain: begin
                busy = 1'b1;
            end
            StDone: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Command datapath: beat address, beats left, direction, stall counter and sticky error.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q      <= '0;
            remaining_q <= '0;
            dir_q       <= 1'b0;
            wait_cnt_q  <= '0;
            error_q     <= 1'b0;
        end else if (start_ok) begin
            addr_q      <= base_addr;
            remaining_q <= length;
            dir_q       <= op_write;
            wait_cnt_q  <= '0;
            error_q     <= 1'b0;
        end else if (beat_ok) begin
            addr_q      <= addr_q + ADDR_W'(ADDR_STEP);
            remaining_q <= remaining_q - LEN_W'(1);
            wait_cnt_q  <= '0;
        end else if (timeout_hit) begin
            error_q    <= 1'b1;
            wait_cnt_q <= '0;
        end else if (state_q == StXfer) begin
            wait_cnt_q <= wait_cnt_q + CntW'(1);
        end
    end

    assign error = error_q;

    avalon_rd_capture #(
        .DATA_W       (DATA_W),
        .READ_LATENCY (READ_LATENCY)
    ) u_rd_capture (
        .clock        (clock),
        .reset        (reset),
        .accept       (rd_accept),
        .avm_readdata (avm_readdata),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .empty        (rd_empty)
    );

endmodule
